// File: rtl/l2cache_pkg.sv
// Shared definitions for the L2 cache front end: FSM encoding, arbitration
// modes and request-buffer field widths.
package l2cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int WSTRB_W  = 4;
  localparam int OPCODE_W = 32;

endpackage

// File: rtl/l2cache_rr_picker.sv
// Combinational request picker: lowest set index in fixed mode, or first set
// index at/after the pointer (cyclically) in round-robin mode.
module l2cache_rr_picker
  import l2cache_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_mode,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic             w_rr;
  int               w_sum;
  logic [IDX_W-1:0] w_j;

  assign w_rr = (i_mode == ARB_RR[0]);

  // Scan from the far end so the nearest candidate is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = 0;
    w_j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = w_rr ? (int'(i_ptr) + k) : k;
      w_j   = IDX_W'(w_sum % N);
      if (i_req[w_j]) begin
        o_idx   = w_j;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2cache_port_arbiter.sv
// L2 front end: arbitrates NUM_PORTS L1 channels plus a cache-op channel onto
// the single L2 core request interface, one outstanding request at a time.
module l2cache_port_arbiter
  import l2cache_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WORDS = 4,
  parameter int ARB_MODE   = 1,
  parameter int PID_W      = $clog2(NUM_PORTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         l1_req,
  input  logic [NUM_PORTS-1:0]         l1_wr,
  input  logic [32*NUM_PORTS-1:0]      l1_addr,
  input  logic [32*NUM_PORTS-1:0]      l1_wdata,
  input  logic [4*NUM_PORTS-1:0]       l1_wstrb,
  output logic [NUM_PORTS-1:0]         l1_addrOK,
  output logic [NUM_PORTS-1:0]         l1_dataOK,
  output logic [32*LINE_WORDS-1:0]     l1_rdata,
  input  logic                         op_req,
  input  logic [OPCODE_W-1:0]          op_code,
  input  logic [ADDR_W-1:0]            op_addr,
  output logic                         op_addrOK,
  output logic                         op_dataOK,
  output logic                         core_req,
  output logic                         core_opflag,
  output logic [OPCODE_W-1:0]          core_opcode,
  output logic                         core_wr,
  output logic [ADDR_W-1:0]            core_addr,
  output logic [WORD_W-1:0]            core_wdata,
  output logic [WSTRB_W-1:0]           core_wstrb,
  output logic [PID_W-1:0]             core_src,
  input  logic                         core_addrOK,
  input  logic                         core_dataOK,
  input  logic [32*LINE_WORDS-1:0]     core_rdata
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_e              r_state;
  state_e              w_state_next;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_opflag;
  logic [OPCODE_W-1:0] r_opcode;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WSTRB_W-1:0]  r_wstrb;
  logic [PID_W-1:0]    r_src;

  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_valid;
  logic                w_idle;
  logic                w_grant_op;
  logic                w_grant_l1;
  logic                w_done;

  l2cache_rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (l1_req),
    .i_ptr   (r_ptr),
    .i_mode  (ARB_MODE == ARB_RR),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Accept/done pulses are combinational, so gate them with rst to keep every
  // handshake output low while reset is held.
  assign w_idle     = (r_state == ST_IDLE) && !rst;
  assign w_grant_op = w_idle && op_req;
  assign w_grant_l1 = w_idle && !op_req && w_pick_valid;
  assign w_done     = !rst && core_dataOK &&
                      (((r_state == ST_SEND) && core_addrOK) || (r_state == ST_WAIT));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_op || w_grant_l1) w_state_next = ST_SEND;
      ST_SEND: if (core_addrOK) w_state_next = core_dataOK ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (core_dataOK) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_opflag <= 1'b0;
      r_opcode <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_src    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_op) begin
        r_opflag <= 1'b1;
        r_opcode <= op_code;
        r_wr     <= 1'b0;
        r_addr   <= op_addr;
        r_wdata  <= '0;
        r_wstrb  <= '0;
        r_src    <= PID_W'(NUM_PORTS);
      end else if (w_grant_l1) begin
        r_opflag <= 1'b0;
        r_opcode <= '0;
        r_wr     <= l1_wr[w_pick_idx];
        r_addr   <= l1_addr[w_pick_idx*ADDR_W +: ADDR_W];
        r_wdata  <= l1_wdata[w_pick_idx*WORD_W +: WORD_W];
        r_wstrb  <= l1_wstrb[w_pick_idx*WSTRB_W +: WSTRB_W];
        r_src    <= PID_W'(w_pick_idx);
        r_ptr    <= (w_pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_pick_idx + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign l1_addrOK[gi] = w_grant_l1 && (w_pick_idx == IDX_W'(gi));
      assign l1_dataOK[gi] = w_done && !r_opflag && (r_src == PID_W'(gi));
    end
  endgenerate

  assign op_addrOK   = w_grant_op;
  assign op_dataOK   = w_done && r_opflag;
  assign l1_rdata    = core_rdata;
  assign core_req    = (r_state == ST_SEND);
  assign core_opflag = r_opflag;
  assign core_opcode = r_opcode;
  assign core_wr     = r_wr;
  assign core_addr   = r_addr;
  assign core_wdata  = r_wdata;
  assign core_wstrb  = r_wstrb;
  assign core_src    = r_src;

endmodule
